mips_multicycle_control: RTL



---
 rtl/mips_multicycle_control.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: sequences fetch/decode/execute/
// memory/writeback with a MemReady wait on every memory access and flags bad opcodes.
module mips_multicycle_control #(
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_ADDI  = 6'b001000,
  parameter logic [5:0] OP_J     = 6'b000010
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] Op,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       IorD,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       AluSrcA,
  output logic [1:0] AluSrcB,
  output logic [1:0] AluOp,
  output logic [1:0] PCSrc,
  output logic       PCEn,
  output logic       Illegal
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11
  } state_t;

  state_t     state, state_nxt;
  logic       mem_read_c, mem_write_c, ir_write_c, iord_c, reg_dst_c;
  logic       mem_to_reg_c, reg_write_c, alu_src_a_c, pc_write_c, branch_c, illegal_c;
  logic [1:0] alu_src_b_c, alu_op_c, pc_src_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH;
    else        state <= state_nxt;
  end

  // Next-state and Moore output decode; MemReady/Zero only qualify enables.
  always_comb begin
    state_nxt    = state;
    mem_read_c   = 1'b0;
    mem_write_c  = 1'b0;
    ir_write_c   = 1'b0;
    iord_c       = 1'b0;
    reg_dst_c    = 1'b0;
    mem_to_reg_c = 1'b0;
    reg_write_c  = 1'b0;
    alu_src_a_c  = 1'b0;
    alu_src_b_c  = 2'b00;
    alu_op_c     = 2'b00;
    pc_src_c     = 2'b00;
    pc_write_c   = 1'b0;
    branch_c     = 1'b0;
    illegal_c    = 1'b0;
    case (state)
      FETCH: begin
        mem_read_c  = 1'b1;
        alu_src_b_c = 2'b01;
        ir_write_c  = MemReady;
        pc_write_c  = MemReady;
        if (MemReady) state_nxt = DECODE;
      end
      DECODE: begin
        alu_src_b_c = 2'b11;
        if (Op == OP_LW || Op == OP_SW) state_nxt = MEMADR;
        else if (Op == OP_RTYPE)        state_nxt = RTYPEEX;
        else if (Op == OP_BEQ)          state_nxt = BEQEX;
        else if (Op == OP_ADDI)         state_nxt = ADDIEX;
        else if (Op == OP_J)            state_nxt = JEX;
        else begin
          state_nxt = FETCH;
          illegal_c = 1'b1;
        end
      end
      MEMADR: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b10;
        state_nxt   = (Op == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        mem_read_c = 1'b1;
        iord_c     = 1'b1;
        if (MemReady) state_nxt = MEMWB;
      end
      MEMWB: begin
        mem_to_reg_c = 1'b1;
        reg_write_c  = 1'b1;
        state_nxt    = FETCH;
      end
      MEMWR: begin
        mem_write_c = 1'b1;
        iord_c      = 1'b1;
        if (MemReady) state_nxt = FETCH;
      end
      RTYPEEX: begin
        alu_src_a_c = 1'b1;
        alu_op_c    = 2'b10;
        state_nxt   = RTYPEWB;
      end
      RTYPEWB: begin
        reg_dst_c   = 1'b1;
        reg_write_c = 1'b1;
        state_nxt   = FETCH;
      end
      BEQEX: begin
        alu_src_a_c = 1'b1;
        alu_op_c    = 2'b01;
        pc_src_c    = 2'b01;
        branch_c    = 1'b1;
        state_nxt   = FETCH;
      end
      ADDIEX: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b10;
        state_nxt   = ADDIWB;
      end
      ADDIWB: begin
        reg_write_c = 1'b1;
        state_nxt   = FETCH;
      end
      JEX: begin
        pc_src_c   = 2'b10;
        pc_write_c = 1'b1;
        state_nxt  = FETCH;
      end
      default: state_nxt = FETCH;
    endcase
  end

  // Reset gates every output so an in-flight write is killed the moment rst_n falls.
  assign MemRead  = rst_n & mem_read_c;
  assign MemWrite = rst_n & mem_write_c;
  assign IRWrite  = rst_n & ir_write_c;
  assign IorD     = rst_n & iord_c;
  assign RegDst   = rst_n & reg_dst_c;
  assign MemtoReg = rst_n & mem_to_reg_c;
  assign RegWrite = rst_n & reg_write_c;
  assign AluSrcA  = rst_n & alu_src_a_c;
  assign AluSrcB  = rst_n ? alu_src_b_c : 2'b00;
  assign AluOp    = rst_n ? alu_op_c    : 2'b00;
  assign PCSrc    = rst_n ? pc_src_c    : 2'b00;
  assign PCEn     = rst_n & (pc_write_c | (branch_c & Zero));
  assign Illegal  = rst_n & illegal_c;

endmodule
